// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared encodings and defaults for the data-memory port arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } arb_owner_e;

    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Width of a down-counter that must hold values 0..lat-1 (never zero bits wide)
    function automatic int lat_cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// rtl/dmem_starve_ctr.sv - saturating count of CPU grants taken while debug waits
module dmem_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat_o = (cnt_q == CNT_W'(STARVE_MAX));

    // Clear wins over increment; increment stops at the saturation value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the multi-cycle data memory between CPU MEM stage and debug port
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int                LAT_W    = lat_cnt_w(MEM_LAT);
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic grant_cpu;
    logic grant_dbg;
    logic starve_sat;
    logic last_cycle;
    logic cpu_done;

    // Counts CPU wins while debug is kept waiting; debug is forced through at saturation
    dmem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (grant_cpu & dbg_req_i),
        .clr_i (~dbg_req_i | grant_dbg),
        .sat_o (starve_sat)
    );

    assign last_cycle  = (state_q == ACCESS) && (lat_cnt_q == '0);
    assign cpu_done    = (state_q == DONE) && (owner_q == OWN_CPU);

    assign mem_en_o    = (state_q == ACCESS);
    // The write strobe waits for the final cycle so a reset mid-access never commits a store
    assign mem_we_o    = last_cycle && we_q;
    assign mem_addr_o  = mem_en_o ? addr_q  : '0;
    assign mem_wdata_o = mem_en_o ? wdata_q : '0;

    assign cpu_stall_o = cpu_req_i & ~cpu_done;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign dbg_ack_o   = (state_q == DONE) && (owner_q == OWN_DBG);

    // Next-state logic: arbitrate only in IDLE, count latency in ACCESS, DONE lasts one cycle
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_cnt_d   = lat_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        grant_cpu   = 1'b0;
        grant_dbg   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    grant_dbg = dbg_req_i & (~cpu_req_i | starve_sat);
                    grant_cpu = cpu_req_i & ~grant_dbg;
                end
                if (grant_cpu || grant_dbg) begin
                    state_d   = ACCESS;
                    lat_cnt_d = LAT_INIT;
                    owner_d   = grant_dbg ? OWN_DBG     : OWN_CPU;
                    we_d      = grant_dbg ? dbg_we_i    : cpu_we_i;
                    addr_d    = grant_dbg ? dbg_addr_i  : cpu_addr_i;
                    wdata_d   = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
                end
            end
            ACCESS: begin
                if (lat_cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q == OWN_CPU) begin
                            cpu_rdata_d = mem_rdata_i;
                        end else begin
                            dbg_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latency counter, request latches and read-data holding registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            lat_cnt_q   <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_cnt_q   <= lat_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_stall_o;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [31:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic [31:0] dbg_rdata_o;
    logic        dbg_ack_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LAT    (LAT),
        .STARVE_MAX (SMAX)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .dbg_req_i   (dbg_req_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_rdata_o (dbg_rdata_o),
        .dbg_ack_o   (dbg_ack_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // Memory model: combinational read, write on the strobe edge
    assign mem_rdata_i = mem[mem_addr_o[7:2]];
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;
    end

    always @(negedge clk) begin
        if (dbg_ack_o) ack_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Single transaction from IDLE: latency, write-strobe count/position, read data
    task automatic do_txn(input bit is_dbg, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output int lat, output int we_cnt, output int we_at);
        bit done;
        lat = -1; we_cnt = 0; we_at = -1; rd = '0;
        @(posedge clk); #1;
        if (is_dbg) begin
            dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd;
        end else begin
            cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_we_o) begin we_cnt++; we_at = i; end
            done = is_dbg ? dbg_ack_o : !cpu_stall_o;
            if (done) begin
                rd  = is_dbg ? dbg_rdata_o : cpu_rdata_o;
                lat = i;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
        dbg_req_i = 1'b0;
    endtask

    // Concurrent CPU burst and optional debug request; grant order predicted from the rules
    task automatic run_mix(input int burst, input bit dbg_en, output int dbg_pos);
        bit exp_q[$];
        int w, c, k;
        bit d;
        w = 0; c = burst; d = dbg_en;
        while (c > 0 || d) begin
            if (c > 0 && d && w != SMAX) begin
                exp_q.push_back(1'b0); c--; w++;
            end else if (d) begin
                exp_q.push_back(1'b1); d = 1'b0; w = 0;
            end else begin
                exp_q.push_back(1'b0); c--;
            end
        end
        c = burst; d = dbg_en; k = 0; dbg_pos = -1;
        @(negedge clk);
        if (c > 0) begin
            cpu_req_i = 1'b1; cpu_we_i = 1'($urandom_range(0, 1));
            cpu_addr_i = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; cpu_wdata_i = $urandom;
        end
        if (d) begin
            dbg_req_i = 1'b1; dbg_we_i = 1'($urandom_range(0, 1));
            dbg_addr_i = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; dbg_wdata_i = $urandom;
        end
        for (int cyc = 0; cyc < 400 && (c > 0 || d); cyc++) begin
            @(negedge clk);
            if (cpu_req_i && !cpu_stall_o) begin
                check("mix_order_cpu", 32'd0, {31'd0, exp_q[k]});
                if (cpu_we_i) ref_mem[cpu_addr_i[7:2]] = cpu_wdata_i;
                else check("mix_cpu_rdata", cpu_rdata_o, ref_mem[cpu_addr_i[7:2]]);
                k++; c--;
                if (c > 0) begin
                    cpu_we_i = 1'($urandom_range(0, 1));
                    cpu_addr_i = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; cpu_wdata_i = $urandom;
                end else begin
                    cpu_req_i = 1'b0;
                end
            end
            if (dbg_ack_o) begin
                check("mix_order_dbg", 32'd1, {31'd0, exp_q[k]});
                check("starve_cleared", 32'(u_dut.u_starve.cnt_q), 32'd0);
                if (dbg_we_i) ref_mem[dbg_addr_i[7:2]] = dbg_wdata_i;
                else check("mix_dbg_rdata", dbg_rdata_o, ref_mem[dbg_addr_i[7:2]]);
                dbg_pos = k;
                k++; d = 1'b0;
                dbg_req_i = 1'b0;
            end
        end
        check("mix_grants", k, exp_q.size());
        @(negedge clk);
    endtask

    typedef struct {
        bit          is_dbg;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [31:0] rd;
        int lat, wc, wa, pos, ack0;
        bit flag, seen;

        vt[0] = '{1'b0, 1'b1, 32'h1c, 32'd42,         32'd0,         LAT + 1};
        vt[1] = '{1'b1, 1'b0, 32'h1c, 32'd0,          32'd42,        LAT + 1};
        vt[2] = '{1'b1, 1'b1, 32'h00, 32'd5,          32'd0,         LAT + 1};
        vt[3] = '{1'b0, 1'b0, 32'h00, 32'd0,          32'd5,         LAT + 1};
        vt[4] = '{1'b0, 1'b0, 32'h1c, 32'd0,          32'd42,        LAT + 1};
        vt[5] = '{1'b1, 1'b1, 32'h30, 32'hdeadbeef,   32'd0,         LAT + 1};
        vt[6] = '{1'b0, 1'b0, 32'h30, 32'd0,          32'hdeadbeef,  LAT + 1};
        vt[7] = '{1'b1, 1'b0, 32'h00, 32'd0,          32'd5,         LAT + 1};

        for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        rst_i = 1'b0; start_i = 1'b1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;

        // Reset for two cycles with requests low
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en",    32'(mem_en_o),    32'd0);
        check("rst_mem_we",    32'(mem_we_o),    32'd0);
        check("rst_mem_addr",  mem_addr_o,       32'd0);
        check("rst_mem_wdata", mem_wdata_o,      32'd0);
        check("rst_cpu_rdata", cpu_rdata_o,      32'd0);
        check("rst_dbg_rdata", dbg_rdata_o,      32'd0);
        check("rst_dbg_ack",   32'(dbg_ack_o),   32'd0);
        check("rst_stall",     32'(cpu_stall_o), 32'd0);
        check("rst_state",     32'(u_dut.state_q), 32'(IDLE));
        @(posedge clk); #1 rst_i = 1'b1;

        // Reset in the first ACCESS cycle of a store of 7 to 0x08
        @(posedge clk); #1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h08; cpu_wdata_i = 32'd7;
        @(posedge clk); #1;
        check("midrst_in_access", 32'(mem_en_o), 32'd1);
        rst_i = 1'b0; cpu_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check("midrst_mem08",  mem[2], 32'd0);
        check("midrst_state",  32'(u_dut.state_q), 32'(IDLE));
        check("midrst_mem_en", 32'(mem_en_o), 32'd0);
        cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            ack0 = ack_cnt;
            do_txn(vt[i].is_dbg, vt[i].we, vt[i].addr, vt[i].wdata, rd, lat, wc, wa);
            check($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
            check($sformatf("vec%0d_we_count", i), wc, vt[i].we ? 1 : 0);
            if (vt[i].we) begin
                check($sformatf("vec%0d_we_cycle", i), wa, LAT);
                ref_mem[vt[i].addr[7:2]] = vt[i].wdata;
            end else begin
                check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            end
            if (vt[i].is_dbg) check($sformatf("vec%0d_ack_pulses", i), ack_cnt - ack0, 1);
        end
        check("cpu_rdata_held", cpu_rdata_o, 32'hdeadbeef);

        // Contention: CPU held continuously, debug waiting
        ack0 = ack_cnt;
        run_mix(6, 1'b1, pos);
        check("contention_dbg_pos", pos, SMAX);
        check("contention_ack_once", ack_cnt - ack0, 1);

        // start_i dropped during a CPU ACCESS with a debug request pending
        @(posedge clk); #1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h1c;
        @(posedge clk); #1;
        start_i = 1'b0;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h00;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (!cpu_stall_o) seen = 1'b1;
        end
        check("nostart_cpu_done", 32'(seen), 32'd1);
        check("nostart_cpu_rdata", cpu_rdata_o, ref_mem[7]);
        @(posedge clk); #1 cpu_req_i = 1'b0;
        flag = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dbg_ack_o || mem_en_o) flag = 1'b1;
        end
        check("nostart_no_grant", 32'(flag), 32'd0);
        start_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (dbg_ack_o) seen = 1'b1;
        end
        check("restart_dbg_ack", 32'(seen), 32'd1);
        check("restart_dbg_rdata", dbg_rdata_o, ref_mem[0]);
        dbg_req_i = 1'b0;
        @(negedge clk);

        // Randomized mixes against the transaction-level model
        for (int it = 0; it < 25; it++) begin
            int b;
            bit de;
            b  = $urandom_range(0, 6);
            de = 1'($urandom_range(0, 1));
            if (b == 0 && !de) b = 1;
            run_mix(b, de, pos);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
